// File: rtl/sim_pkg.sv
// Shared types and constants for the generation sequencer.
package sim_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } seq_state_t;

    // Default generation-counter width.
    localparam int unsigned CNT_W_DEFAULT = 16;

    // Default lowest divider bit used for tick generation.
    localparam int unsigned BASE_BIT_DEFAULT = 22;

    // Speed selector width and fastest setting.
    localparam int unsigned SPEED_W = 2;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 2'd3;

    // Divider bits kept above BASE_BIT: one per speed step.
    localparam int unsigned DIV_EXTRA = 4;

    // Divider bit index for a given speed: slowest uses the highest bit.
    function automatic int unsigned speed_bit(input int unsigned base_bit,
                                              input logic [SPEED_W-1:0] speed);
        logic [SPEED_W-1:0] ofs;
        ofs = SPEED_MAX - speed;
        return base_bit + {{(32-SPEED_W){1'b0}}, ofs};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider with a selectable tap and rising-edge tick output.
module tick_gen
    import sim_pkg::*;
#(
    parameter int unsigned BASE_BIT = BASE_BIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SPEED_W-1:0] speed_sel,
    output logic               tick
);

    localparam int unsigned DIV_W = BASE_BIT + DIV_EXTRA;
    localparam int unsigned IDX_W = $clog2(DIV_W);

    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_bit;
    logic             samp_q;

    // Divider counts every cycle and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Pick the divider tap for the current speed.
    always_comb begin
        sel_idx = IDX_W'(speed_bit(BASE_BIT, speed_sel));
        sel_bit = div_q[sel_idx];
    end

    // The sample always follows the currently selected tap, so a speed change
    // can raise at most one tick (new tap high against the old tap's sample).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= 1'b0;
        end else begin
            samp_q <= sel_bit;
        end
    end

    // One-cycle tick on the rising edge of the selected tap.
    always_comb begin
        tick = sel_bit & ~samp_q;
    end

endmodule

// File: rtl/sim_sequencer.sv
// Generation sequencer: issues start pulses on step edges or run ticks,
// waits for datapath completion and counts finished generations.
module sim_sequencer
    import sim_pkg::*;
#(
    parameter int unsigned BASE_BIT = BASE_BIT_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic [SPEED_W-1:0] speed_sel,
    input  logic               clear,
    input  logic               gen_done,
    output logic               gen_start,
    output logic               busy,
    output logic [CNT_W-1:0]   gen_count,
    output logic               overrun
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] gen_count_q, gen_count_d;
    logic             overrun_q, overrun_d;
    logic             step_q;
    logic             step_arm_q;
    logic             step_edge;
    logic             tick;
    logic             run_tick;

    tick_gen #(
        .BASE_BIT (BASE_BIT)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

    // Step button history; the arm bit stays low until the button has been
    // seen low once, so a button held through reset is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q     <= 1'b0;
            step_arm_q <= 1'b0;
        end else begin
            step_q     <= step_btn;
            step_arm_q <= step_arm_q | ~step_btn;
        end
    end

    // Request sources for the FSM.
    always_comb begin
        step_edge = step_btn & ~step_q & step_arm_q;
        run_tick  = tick & run_sw;
    end

    // State, counter and overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gen_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_count_q <= gen_count_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, start/busy outputs, counter and overrun updates.
    always_comb begin
        state_d     = state_q;
        gen_count_d = gen_count_q;
        overrun_d   = overrun_q;
        gen_start   = 1'b0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                // Step and tick together still yield a single issue.
                if (step_edge || run_tick) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gen_start = 1'b1;
                busy      = 1'b1;
                state_d   = BUSY;
                if (run_tick) begin
                    overrun_d = 1'b1;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (run_tick) begin
                    overrun_d = 1'b1;
                end
                if (gen_done) begin
                    gen_count_d = gen_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides any increment or overrun set in the same cycle.
        if (clear) begin
            gen_count_d = '0;
            overrun_d   = 1'b0;
        end
    end

    // Registered status outputs.
    always_comb begin
        gen_count = gen_count_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_sim_sequencer.sv
// Self-checking bench for sim_sequencer with a completion-count scoreboard.
module tb_sim_sequencer;

    localparam int unsigned BASE_BIT = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MOD  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run_sw;
    logic             step_btn;
    logic [1:0]       speed_sel;
    logic             clear;
    logic             gen_done;
    logic             gen_start;
    logic             busy;
    logic [CNT_W-1:0] gen_count;
    logic             overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int m_count = 0;
    int exp_q[$];
    int exp_c;

    sim_sequencer #(
        .BASE_BIT (BASE_BIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .speed_sel (speed_sel),
        .clear     (clear),
        .gen_done  (gen_done),
        .gen_start (gen_start),
        .busy      (busy),
        .gen_count (gen_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse gen_done for one cycle and record the expected count.
    task automatic drive_done();
        gen_done = 1'b1;
        m_count  = (m_count + 1) % CNT_MOD;
        exp_q.push_back(m_count);
        step_cyc();
        gen_done = 1'b0;
    endtask

    // Wait (bounded) until gen_start is observed high.
    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (gen_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            step_cyc();
        end
    endtask

    task automatic test_reset();
        int starts;
        rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; speed_sel = 2'd3;
        clear = 1'b0; gen_done = 1'b0;
        repeat (2) step_cyc();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if (gen_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b want 0", gen_start); end
        tests++; if (gen_count !== '0) begin fails++; $display("FAIL rst_count: got %0d want 0", gen_count); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        rst_n = 1'b1;
        repeat (2) step_cyc();

        // One complete generation so the count is nonzero.
        step_btn = 1'b1;
        step_cyc();
        tests++; if (gen_start !== 1'b1) begin fails++; $display("FAIL rst_first_start: got %b want 1", gen_start); end
        step_btn = 1'b0;
        step_cyc();
        drive_done();
        exp_c = exp_q.pop_front();
        tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL rst_first_count: got %0d want %0d", gen_count, exp_c); end

        // Second generation, reset while BUSY.
        step_btn = 1'b1;
        step_cyc();
        step_btn = 1'b0;
        step_cyc();
        step_cyc();
        #2 rst_n = 1'b0;
        #1;
        m_count = 0;
        exp_q.delete();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        tests++; if (gen_count !== '0) begin fails++; $display("FAIL rst_mid_count: got %0d want 0", gen_count); end
        step_cyc();
        rst_n = 1'b1;
        repeat (3) step_cyc();
        gen_done = 1'b1;
        step_cyc();
        gen_done = 1'b0;
        tests++; if (gen_count !== '0) begin fails++; $display("FAIL rst_late_done: got %0d want 0", gen_count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_late_busy: got %b want 0", busy); end

        // Step held high through reset release must not count as an edge.
        step_btn = 1'b1;
        rst_n = 1'b0;
        step_cyc();
        rst_n = 1'b1;
        m_count = 0;
        starts = 0;
        repeat (6) begin
            step_cyc();
            if (gen_start === 1'b1) starts++;
        end
        tests++; if (starts !== 0) begin fails++; $display("FAIL rst_step_held: got %0d starts want 0", starts); end
        step_btn = 1'b0;
        step_cyc();
        step_btn = 1'b1;
        step_cyc();
        tests++; if (gen_start !== 1'b1) begin fails++; $display("FAIL rst_step_rearm: got %b want 1", gen_start); end
        step_btn = 1'b0;
        step_cyc();
        drive_done();
        exp_c = exp_q.pop_front();
        tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL rst_rearm_count: got %0d want %0d", gen_count, exp_c); end
    endtask

    task automatic test_step();
        run_sw = 1'b0;
        // gen_done while idle is ignored.
        gen_done = 1'b1;
        step_cyc();
        gen_done = 1'b0;
        step_cyc();
        tests++; if (gen_count !== CNT_W'(m_count)) begin fails++; $display("FAIL step_done_idle: got %0d want %0d", gen_count, m_count); end

        step_btn = 1'b1;
        step_cyc();
        tests++; if (gen_start !== 1'b1) begin fails++; $display("FAIL step_start: got %b want 1", gen_start); end
        step_btn = 1'b0;
        step_cyc();
        tests++; if (gen_start !== 1'b0) begin fails++; $display("FAIL step_start_width: got %b want 0", gen_start); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL step_busy: got %b want 1", busy); end
        repeat (4) step_cyc();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL step_busy_hold: got %b want 1", busy); end
        drive_done();
        exp_c = exp_q.pop_front();
        tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL step_count: got %0d want %0d", gen_count, exp_c); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL step_idle: got %b want 0", busy); end
    endtask

    task automatic test_run();
        int last;
        bit found;
        clear = 1'b1;
        m_count = 0;
        step_cyc();
        clear = 1'b0;
        tests++; if (gen_count !== '0) begin fails++; $display("FAIL run_clear: got %0d want 0", gen_count); end
        speed_sel = 2'd3;
        run_sw = 1'b1;
        last = -1;
        for (int i = 0; i < 16; i++) begin
            wait_start(20, found);
            if (!found) begin
                tests++; fails++;
                $display("FAIL run_timeout: gen_start=%b want 1 within 20 cycles (gen %0d)", gen_start, i);
                break;
            end
            if (last >= 0) begin
                tests++; if (cyc - last !== 8) begin fails++; $display("FAIL run_period: got %0d want 8", cyc - last); end
            end
            last = cyc;
            step_cyc();
            step_cyc();
            drive_done();
            exp_c = exp_q.pop_front();
            tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL run_count: got %0d want %0d", gen_count, exp_c); end
        end
        run_sw = 1'b0;
        tests++; if (gen_count !== '0) begin fails++; $display("FAIL run_wrap: got %0d want 0", gen_count); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL run_overrun: got %b want 0", overrun); end
        repeat (10) step_cyc();
    endtask

    task automatic test_overrun();
        bit found;
        speed_sel = 2'd3;
        run_sw = 1'b1;
        wait_start(20, found);
        tests++; if (!found) begin fails++; $display("FAIL ovr_timeout: gen_start=%b want 1", gen_start); end
        for (int k = 1; k <= 20; k++) begin
            step_cyc();
            if (k == 5) begin
                tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_early: got %b want 0", overrun); end
            end
            if (k == 12) begin
                tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", overrun); end
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovr_busy: got %b want 1", busy); end
            end
        end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        gen_done = 1'b1;
        clear = 1'b1;
        run_sw = 1'b0;
        m_count = 0;
        exp_q.push_back(m_count);
        step_cyc();
        gen_done = 1'b0;
        clear = 1'b0;
        exp_c = exp_q.pop_front();
        tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL ovr_clear_count: got %0d want %0d", gen_count, exp_c); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear_flag: got %b want 0", overrun); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovr_idle: got %b want 0", busy); end
        repeat (10) step_cyc();
    endtask

    task automatic test_collision();
        bit found;
        int starts;
        speed_sel = 2'd3;
        run_sw = 1'b1;
        wait_start(20, found);
        tests++; if (!found) begin fails++; $display("FAIL col_timeout: gen_start=%b want 1", gen_start); end
        step_cyc();
        step_cyc();
        drive_done();
        exp_c = exp_q.pop_front();
        tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL col_pre_count: got %0d want %0d", gen_count, exp_c); end
        repeat (4) step_cyc();
        // The next run tick falls in this cycle; raise the step with it.
        step_btn = 1'b1;
        starts = 0;
        for (int k = 0; k < 18; k++) begin
            step_cyc();
            if (gen_start === 1'b1) starts++;
            if (k == 0) begin
                tests++; if (gen_start !== 1'b1) begin fails++; $display("FAIL col_start: got %b want 1", gen_start); end
                run_sw = 1'b0;
            end
            if (k == 1) step_btn = 1'b0;
            if (k == 2) step_btn = 1'b1;
            if (k == 3) begin
                gen_done = 1'b1;
                m_count = (m_count + 1) % CNT_MOD;
                exp_q.push_back(m_count);
            end
            if (k == 4) begin
                gen_done = 1'b0;
                exp_c = exp_q.pop_front();
                tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL col_count: got %0d want %0d", gen_count, exp_c); end
            end
        end
        step_btn = 1'b0;
        tests++; if (starts !== 1) begin fails++; $display("FAIL col_starts: got %0d want 1", starts); end
        step_cyc();
    endtask

    task automatic test_speed_change();
        bit found;
        int chg;
        int wait_cnt;
        int st[$];
        speed_sel = 2'd3;
        run_sw = 1'b1;
        wait_start(20, found);
        tests++; if (!found) begin fails++; $display("FAIL spd_timeout: gen_start=%b want 1", gen_start); end
        step_cyc();
        step_cyc();
        drive_done();
        exp_c = exp_q.pop_front();
        tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL spd_pre_count: got %0d want %0d", gen_count, exp_c); end
        speed_sel = 2'd0;
        chg = cyc;
        wait_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            step_cyc();
            if (gen_done === 1'b1) begin
                gen_done = 1'b0;
                exp_c = exp_q.pop_front();
                tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL spd_count: got %0d want %0d", gen_count, exp_c); end
            end
            if (gen_start === 1'b1) begin
                st.push_back(cyc);
                wait_cnt = 2;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    gen_done = 1'b1;
                    m_count = (m_count + 1) % CNT_MOD;
                    exp_q.push_back(m_count);
                end
            end
        end
        run_sw = 1'b0;
        if (gen_done === 1'b1) begin
            step_cyc();
            gen_done = 1'b0;
            exp_c = exp_q.pop_front();
            tests++; if (gen_count !== CNT_W'(exp_c)) begin fails++; $display("FAIL spd_last_count: got %0d want %0d", gen_count, exp_c); end
        end
        // A single start right after the change is allowed.
        if (st.size() > 0 && st[0] == chg + 1) void'(st.pop_front());
        tests++; if (st.size() < 2) begin fails++; $display("FAIL spd_starts: got %0d starts want >= 2", st.size()); end
        if (st.size() > 0) begin
            tests++; if (st[0] - chg > 65) begin fails++; $display("FAIL spd_first: got %0d cycles want <= 65", st[0] - chg); end
        end
        for (int i = 1; i < st.size(); i++) begin
            tests++; if (st[i] - st[i-1] !== 64) begin fails++; $display("FAIL spd_period: got %0d want 64", st[i] - st[i-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_overrun();
        test_collision();
        test_speed_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
